// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD timing generator: axis phase encoding,
// default panel timing and the colour-bar palette.
package lcd_pkg;

   typedef enum logic [1:0] {
      PH_SYNC   = 2'd0,
      PH_BACK   = 2'd1,
      PH_ACTIVE = 2'd2,
      PH_FRONT  = 2'd3
   } phase_t;

   localparam int unsigned DEF_H_ACTIVE = 480;
   localparam int unsigned DEF_H_PULSE  = 4;
   localparam int unsigned DEF_H_BP     = 43;
   localparam int unsigned DEF_H_FP     = 8;
   localparam int unsigned DEF_V_ACTIVE = 272;
   localparam int unsigned DEF_V_PULSE  = 4;
   localparam int unsigned DEF_V_BP     = 12;
   localparam int unsigned DEF_V_FP     = 8;
   localparam int unsigned DEF_WIN_X    = 160;
   localparam int unsigned DEF_WIN_Y    = 18;
   localparam int unsigned WIN_SIZE     = 256;

   // RGB565 colour of bar 0..7, left to right.
   function automatic logic [15:0] bar_rgb565(input logic [2:0] bar);
      bar_rgb565 = 16'h0000;
      case (bar)
         3'd0: bar_rgb565 = 16'hFFFF;
         3'd1: bar_rgb565 = 16'hFFE0;
         3'd2: bar_rgb565 = 16'h07FF;
         3'd3: bar_rgb565 = 16'h07E0;
         3'd4: bar_rgb565 = 16'hF81F;
         3'd5: bar_rgb565 = 16'hF800;
         3'd6: bar_rgb565 = 16'h001F;
         default: bar_rgb565 = 16'h0000;
      endcase
   endfunction

endpackage

// File: rtl/lcd_axis_fsm.sv
// One timing axis: SYNC -> BACK -> ACTIVE -> FRONT phase FSM with an in-phase
// counter. Next-state values are exported so the top can look one clock ahead.
module lcd_axis_fsm
   import lcd_pkg::*;
#(
   parameter int unsigned P_PULSE  = 4,
   parameter int unsigned P_BACK   = 43,
   parameter int unsigned P_ACTIVE = 480,
   parameter int unsigned P_FRONT  = 8,
   parameter int unsigned CNT_W    = 10
) (
   input  logic             pixel_clk,
   input  logic             rst,
   input  logic             advance,
   output phase_t           phase,
   output logic [CNT_W-1:0] cnt,
   output phase_t           phase_nxt,
   output logic [CNT_W-1:0] cnt_nxt,
   output logic             wrap
);

   localparam logic [CNT_W-1:0] PULSE_M1  = CNT_W'(P_PULSE - 1);
   localparam logic [CNT_W-1:0] BACK_M1   = CNT_W'(P_BACK - 1);
   localparam logic [CNT_W-1:0] ACTIVE_M1 = CNT_W'(P_ACTIVE - 1);
   localparam logic [CNT_W-1:0] FRONT_M1  = CNT_W'(P_FRONT - 1);

   logic [CNT_W-1:0] len_m1;

   always_ff @(posedge pixel_clk or negedge rst) begin
      if (!rst) begin
         phase <= PH_SYNC;
         cnt   <= '0;
      end else begin
         phase <= phase_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // The counter restarts at zero on every phase change; wrap marks the
   // last clock of FRONT so the next axis up can advance.
   always_comb begin
      len_m1    = PULSE_M1;
      phase_nxt = phase;
      cnt_nxt   = cnt;
      wrap      = 1'b0;
      case (phase)
         PH_SYNC:   len_m1 = PULSE_M1;
         PH_BACK:   len_m1 = BACK_M1;
         PH_ACTIVE: len_m1 = ACTIVE_M1;
         default:   len_m1 = FRONT_M1;
      endcase
      if (advance) begin
         if (cnt == len_m1) begin
            cnt_nxt = '0;
            case (phase)
               PH_SYNC:   phase_nxt = PH_BACK;
               PH_BACK:   phase_nxt = PH_ACTIVE;
               PH_ACTIVE: phase_nxt = PH_FRONT;
               default: begin
                  phase_nxt = PH_SYNC;
                  wrap      = 1'b1;
               end
            endcase
         end else begin
            cnt_nxt = cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD panel timing generator with a 256x256 frame-buffer window and a
// look-ahead RAM address. Define LCD_TESTPAT_EN to add the tp_rgb colour bars.
module lcd_timing_gen
   import lcd_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_PULSE  = DEF_H_PULSE,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_PULSE  = DEF_V_PULSE,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned WIN_X    = DEF_WIN_X,
   parameter int unsigned WIN_Y    = DEF_WIN_Y
) (
   input  logic        pixel_clk,
   input  logic        rst,
   output logic        lcd_hsync_n,
   output logic        lcd_vsync_n,
   output logic        lcd_den,
   output logic [9:0]  pix_x,
   output logic [8:0]  pix_y,
   output logic        line_start,
   output logic        frame_start,
   output logic        win_valid,
   output logic [11:0] win_addr
`ifdef LCD_TESTPAT_EN
   ,
   output logic [15:0] tp_rgb
`endif
);

   localparam logic [10:0] WX_LO = 11'(WIN_X);
   localparam logic [10:0] WX_HI = 11'(WIN_X + WIN_SIZE);
   localparam logic [9:0]  WY_LO = 10'(WIN_Y);
   localparam logic [9:0]  WY_HI = 10'(WIN_Y + WIN_SIZE);
   localparam logic [7:0]  WIN_X8 = 8'(WIN_X);
   localparam logic [7:0]  WIN_Y8 = 8'(WIN_Y);

   logic       run;
   logic       line_entry;
   logic       frame_entry;
   phase_t     h_phase, h_phase_nxt, v_phase, v_phase_nxt;
   logic [9:0] h_cnt, h_cnt_nxt;
   logic [8:0] v_cnt, v_cnt_nxt;
   logic       h_wrap, v_wrap;

   lcd_axis_fsm #(
      .P_PULSE(H_PULSE), .P_BACK(H_BP), .P_ACTIVE(H_ACTIVE), .P_FRONT(H_FP), .CNT_W(10)
   ) u_h_fsm (
      .pixel_clk(pixel_clk), .rst(rst), .advance(run),
      .phase(h_phase), .cnt(h_cnt), .phase_nxt(h_phase_nxt), .cnt_nxt(h_cnt_nxt),
      .wrap(h_wrap)
   );

   lcd_axis_fsm #(
      .P_PULSE(V_PULSE), .P_BACK(V_BP), .P_ACTIVE(V_ACTIVE), .P_FRONT(V_FP), .CNT_W(9)
   ) u_v_fsm (
      .pixel_clk(pixel_clk), .rst(rst), .advance(run && h_wrap),
      .phase(v_phase), .cnt(v_cnt), .phase_nxt(v_phase_nxt), .cnt_nxt(v_cnt_nxt),
      .wrap(v_wrap)
   );

   function automatic logic in_win(input phase_t hp, input logic [9:0] x,
                                   input phase_t vp, input logic [8:0] y);
      return (hp == PH_ACTIVE) && (vp == PH_ACTIVE) &&
             ({1'b0, x} >= WX_LO) && ({1'b0, x} < WX_HI) &&
             ({1'b0, y} >= WY_LO) && ({1'b0, y} < WY_HI);
   endfunction

`ifdef LCD_TESTPAT_EN
   localparam int unsigned BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
   logic [9:0] bar_idx;
   logic [2:0] bar_sel;
   assign bar_idx = h_cnt / 10'(BAR_W);
   assign bar_sel = (bar_idx > 10'd7) ? 3'd7 : bar_idx[2:0];
`endif

   // run holds the FSMs for one clock after reset release, so the first
   // registered output of the frame lands on the second edge.
   always_ff @(posedge pixel_clk or negedge rst) begin
      if (!rst) begin
         run         <= 1'b0;
         line_entry  <= 1'b1;
         frame_entry <= 1'b1;
         lcd_hsync_n <= 1'b1;
         lcd_vsync_n <= 1'b1;
         lcd_den     <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         win_valid   <= 1'b0;
         win_addr    <= '0;
`ifdef LCD_TESTPAT_EN
         tp_rgb      <= '0;
`endif
      end else begin
         run <= 1'b1;
         if (run) begin
            line_entry  <= h_wrap;
            frame_entry <= v_wrap;
            lcd_hsync_n <= (h_phase != PH_SYNC);
            lcd_vsync_n <= (v_phase != PH_SYNC);
            lcd_den     <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
            pix_x       <= (h_phase == PH_ACTIVE) ? h_cnt : '0;
            pix_y       <= (v_phase == PH_ACTIVE) ? v_cnt : '0;
            line_start  <= line_entry;
            frame_start <= line_entry && frame_entry;
            win_valid   <= in_win(h_phase, h_cnt, v_phase, v_cnt);
            // Address of the pixel the FSMs move to next; held outside the window.
            if (in_win(h_phase_nxt, h_cnt_nxt, v_phase_nxt, v_cnt_nxt)) begin
               win_addr <= {6'((v_cnt_nxt[7:0] - WIN_Y8) >> 2),
                            6'((h_cnt_nxt[7:0] - WIN_X8) >> 2)};
            end
`ifdef LCD_TESTPAT_EN
            tp_rgb <= ((h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE)) ?
                      bar_rgb565(bar_sel) : 16'h0000;
`endif
         end
      end
   end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench: default-timing instance for line/pixel/window checks and a
// tiny-timing instance for frame period and wrap.
module tb_lcd_timing_gen;

   logic        pixel_clk;
   logic        rst;
   int          cyc;
   int          n_cmp;
   int          n_bad;

   logic        lcd_hsync_n, lcd_vsync_n, lcd_den, line_start, frame_start, win_valid;
   logic [9:0]  pix_x;
   logic [8:0]  pix_y;
   logic [11:0] win_addr;
   logic        s_hsync_n, s_vsync_n, s_den, s_line_start, s_frame_start, s_win_valid;
   logic [9:0]  s_pix_x;
   logic [8:0]  s_pix_y;
   logic [11:0] s_win_addr;
`ifdef LCD_TESTPAT_EN
   logic [15:0] tp_rgb, s_tp_rgb;
`endif

   lcd_timing_gen dut (
      .pixel_clk(pixel_clk), .rst(rst),
      .lcd_hsync_n(lcd_hsync_n), .lcd_vsync_n(lcd_vsync_n), .lcd_den(lcd_den),
      .pix_x(pix_x), .pix_y(pix_y), .line_start(line_start), .frame_start(frame_start),
      .win_valid(win_valid), .win_addr(win_addr)
`ifdef LCD_TESTPAT_EN
      , .tp_rgb(tp_rgb)
`endif
   );

   lcd_timing_gen #(
      .H_ACTIVE(16), .H_PULSE(2), .H_BP(1), .H_FP(1),
      .V_ACTIVE(8), .V_PULSE(2), .V_BP(1), .V_FP(1),
      .WIN_X(4), .WIN_Y(2)
   ) dut_s (
      .pixel_clk(pixel_clk), .rst(rst),
      .lcd_hsync_n(s_hsync_n), .lcd_vsync_n(s_vsync_n), .lcd_den(s_den),
      .pix_x(s_pix_x), .pix_y(s_pix_y), .line_start(s_line_start), .frame_start(s_frame_start),
      .win_valid(s_win_valid), .win_addr(s_win_addr)
`ifdef LCD_TESTPAT_EN
      , .tp_rgb(s_tp_rgb)
`endif
   );

   // clock / reset
   initial begin
      pixel_clk = 1'b0;
      forever #5 pixel_clk = ~pixel_clk;
   end

   always @(posedge pixel_clk) cyc <= cyc + 1;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running, want finished");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge pixel_clk);
   endtask

   task automatic wait_ls(input string tag);
      int n;
      n = 0;
      step();
      while (!line_start && n < 1000) begin
         step();
         n++;
      end
      if (!line_start) check_eq(tag, 32'(line_start), 32'd1);
   endtask

   // monitor for the small instance (20 x 12 total, frame = 240 clocks)
   logic        mon_en;
   int          s_fs_t[3];
   int          s_nfs;
   int          s_last_ls;
   logic        s_ls_seen;
   int          s_per_min, s_per_max;
   int          s_den_cnt;
   logic [11:0] s_prev_addr, s_addr_15_7;
   logic        s_wv_3_7, s_wv_4_2;

   initial begin
      s_nfs = 0; s_ls_seen = 1'b0; s_per_min = 99999; s_per_max = 0; s_den_cnt = 0;
      s_prev_addr = '0; s_addr_15_7 = '0; s_wv_3_7 = 1'b1; s_wv_4_2 = 1'b0; s_last_ls = 0;
   end

   always @(negedge pixel_clk) begin
      if (mon_en) begin
         if (s_line_start) begin
            if (s_ls_seen) begin
               if (cyc - s_last_ls < s_per_min) s_per_min = cyc - s_last_ls;
               if (cyc - s_last_ls > s_per_max) s_per_max = cyc - s_last_ls;
            end
            s_last_ls = cyc;
            s_ls_seen = 1'b1;
         end
         if (s_frame_start) begin
            if (s_nfs < 3) s_fs_t[s_nfs] = cyc;
            s_nfs++;
         end
         if (s_nfs == 1 && s_den) begin
            s_den_cnt++;
            if (s_pix_x == 10'd15 && s_pix_y == 9'd7) s_addr_15_7 = s_prev_addr;
            if (s_pix_x == 10'd3 && s_pix_y == 9'd7) s_wv_3_7 = s_win_valid;
            if (s_pix_x == 10'd4 && s_pix_y == 9'd2) s_wv_4_2 = s_win_valid;
         end
         s_prev_addr = s_win_addr;
      end
   end

   initial begin
      int          n;
      int          len;
      int          bad;
      int          t_ls;
      int          t_fs0;
      logic [11:0] prev;
      logic [11:0] got415;
      n_cmp = 0; n_bad = 0; cyc = 0; mon_en = 1'b1;
      rst = 1'b1;
      #1 rst = 1'b0;
      repeat (3) step();

      check_eq("rst_hsync_n", 32'(lcd_hsync_n), 32'd1);
      check_eq("rst_vsync_n", 32'(lcd_vsync_n), 32'd1);
      check_eq("rst_den", 32'(lcd_den), 32'd0);
      check_eq("rst_ls_fs", {30'd0, line_start, frame_start}, 32'd0);
      check_eq("rst_pix", {13'd0, pix_y, pix_x}, 32'd0);
      check_eq("rst_win", {19'd0, win_valid, win_addr}, 32'd0);

      rst = 1'b1;
      step();
      check_eq("edge1_line_start", 32'(line_start), 32'd0);
      step();
      check_eq("edge2_line_start", 32'(line_start), 32'd1);
      check_eq("edge2_frame_start", 32'(frame_start), 32'd1);
      check_eq("edge2_vsync_n", 32'(lcd_vsync_n), 32'd0);
      check_eq("small_frame_start", 32'(s_frame_start), 32'd1);
      t_ls  = cyc;
      t_fs0 = cyc;
      n = 0;
      while (!lcd_hsync_n && n < 100) begin
         n++;
         step();
      end
      check_eq("hsync_width", 32'(n), 32'd4);

      for (int i = 1; i <= 100; i++) begin
         wait_ls("line_start_timeout");
         if (i == 1 || i == 99) check_eq("line_period", 32'(cyc - t_ls), 32'd535);
         t_ls = cyc;
         if (i == 1) check_eq("frame_start_line1", 32'(frame_start), 32'd0);
         if (i == 3) check_eq("vsync_line3", 32'(lcd_vsync_n), 32'd0);
         if (i == 4) check_eq("vsync_line4", 32'(lcd_vsync_n), 32'd1);
         if (i == 15) check_eq("line15_pix_y", 32'(pix_y), 32'd0);
         if (i == 16) begin
            n = 0;
            while (!lcd_den && n < 600) begin
               step();
               n++;
            end
            check_eq("den_delay", 32'(n), 32'd47);
            check_eq("den_rise_pix_y", 32'(pix_y), 32'd0);
            len = 0;
            bad = 0;
            while (lcd_den && len < 600) begin
               if (pix_x != 10'(len)) bad++;
`ifdef LCD_TESTPAT_EN
               if (pix_x == 10'd0)   check_eq("tp_x0", 32'(tp_rgb), 32'hFFFF);
               if (pix_x == 10'd60)  check_eq("tp_x60", 32'(tp_rgb), 32'hFFE0);
               if (pix_x == 10'd479) check_eq("tp_x479", 32'(tp_rgb), 32'h0000);
`endif
               len++;
               step();
            end
            check_eq("den_len", 32'(len), 32'd480);
            check_eq("pix_x_seq_errs", 32'(bad), 32'd0);
            check_eq("pix_x_after_den", 32'(pix_x), 32'd0);
         end
         if (i == 34 || i == 38) begin
            n = 0;
            prev = win_addr;
            step();
            while (!win_valid && n < 600) begin
               prev = win_addr;
               step();
               n++;
            end
            check_eq("win_rise_pix_x", 32'(pix_x), 32'd160);
            check_eq("win_rise_pix_y", 32'(pix_y), (i == 34) ? 32'd18 : 32'd22);
            check_eq("win_rise_addr", 32'(prev), (i == 34) ? 32'h000 : 32'h040);
            if (i == 34) begin
               got415 = 12'h000;
               while (win_valid && n < 1200) begin
                  prev = win_addr;
                  step();
                  n++;
                  if (win_valid && pix_x == 10'd415) got415 = prev;
               end
               check_eq("win_addr_415", 32'(got415), 32'h03F);
               check_eq("win_fall_pix_x", 32'(pix_x), 32'd416);
               check_eq("win_fall_den", 32'(lcd_den), 32'd1);
            end
         end
      end

      // small instance: frame period, seamless wrap, window corner cases
      check_eq("s_frame_count", 32'(s_nfs >= 3), 32'd1);
      check_eq("s_first_frame_t", 32'(s_fs_t[0]), 32'(t_fs0));
      check_eq("s_frame_period0", 32'(s_fs_t[1] - s_fs_t[0]), 32'd240);
      check_eq("s_frame_period1", 32'(s_fs_t[2] - s_fs_t[1]), 32'd240);
      check_eq("s_line_period_min", 32'(s_per_min), 32'd20);
      check_eq("s_line_period_max", 32'(s_per_max), 32'd20);
      check_eq("s_den_per_frame", 32'(s_den_cnt), 32'd128);
      check_eq("s_addr_15_7", 32'(s_addr_15_7), 32'h042);
      check_eq("s_wv_3_7", 32'(s_wv_3_7), 32'd0);
      check_eq("s_wv_4_2", 32'(s_wv_4_2), 32'd1);

      // mid-frame reset on line 100
      mon_en = 1'b0;
      repeat (200) step();
      check_eq("pre_rst_den", 32'(lcd_den), 32'd1);
      check_eq("pre_rst_pix_x", 32'(pix_x), 32'd153);
      check_eq("pre_rst_pix_y", 32'(pix_y), 32'd84);
      #2 rst = 1'b0;
      #1;
      check_eq("mid_rst_den", 32'(lcd_den), 32'd0);
      check_eq("mid_rst_pix", {13'd0, pix_y, pix_x}, 32'd0);
      check_eq("mid_rst_hsync_n", 32'(lcd_hsync_n), 32'd1);
      step();
      step();
      rst = 1'b1;
      step();
      check_eq("restart_edge1_fs", 32'(frame_start), 32'd0);
      step();
      check_eq("restart_frame_start", 32'(frame_start), 32'd1);
      check_eq("restart_hsync_n", 32'(lcd_hsync_n), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
